// File: rtl/rfifo_stream_rd_if.sv
// Stream port of the read-domain FIFO consumer.
// Handshake: a word transfers on every rclk edge where m_valid && m_ready.
// Once m_valid is high, m_valid and m_data stay unchanged until that
// transfer happens; m_ready may change freely and never waits on m_valid.
interface rfifo_stream_rd_if #(
  parameter int DATASIZE = 8
);
  logic                m_valid;
  logic                m_ready;
  logic [DATASIZE-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/rfifo_stream_rd.sv
// Read-domain side of a dual-clock FIFO. It owns the read pointer, fetches
// words from a memory with one cycle of registered read latency, and hides
// that latency behind a 2-entry prefetch/skid buffer so the stream can move
// one word per rclk while m_ready stays high.
module rfifo_stream_rd #(
  parameter int ADDRSIZE      = 4,
  parameter int DATASIZE      = 8,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                ren,
  input  logic [DATASIZE-1:0] rdata_mem,
  rfifo_stream_rd_if.master   m_if,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                aempty,
  output logic                rempty
);

  // Binary read counter; its low bits address the memory.
  logic [ADDRSIZE:0]   r_rbin;
  // slot0 presents the stream word, slot1 absorbs a word that returns
  // while slot0 is still waiting for the consumer.
  logic                r_s0_v;
  logic [DATASIZE-1:0] r_s0_d;
  logic                r_s1_v;
  logic [DATASIZE-1:0] r_s1_d;
  // A memory read issued last cycle whose data is on rdata_mem now.
  logic                r_inflight;

  logic [ADDRSIZE:0]   w_wbin;
  logic [ADDRSIZE:0]   w_avail;
  logic [ADDRSIZE:0]   w_avail_next;
  logic [ADDRSIZE:0]   w_rbin_next;
  logic [ADDRSIZE:0]   w_rlevel_next;
  logic [1:0]          w_occ;
  logic [1:0]          w_occ_next;
  logic                w_pop;
  logic                w_ren;
  logic                w_s0_v_n;
  logic [DATASIZE-1:0] w_s0_d_n;
  logic                w_s1_v_n;
  logic [DATASIZE-1:0] w_s1_d_n;

  // Gray-to-binary of the synchronized write pointer: each bit is the XOR
  // of itself and every more significant Gray bit.
  always_comb begin
    w_wbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      w_wbin[i] = ^(rq2_wptr >> i);
    end
  end

  // Read issue: fetch while memory holds unread words and the buffer plus
  // the in-flight read leave room after this cycle's pop. Gating with
  // rrst_n keeps ren low for the whole reset, even with a live write pointer.
  always_comb begin
    w_avail     = w_wbin - r_rbin;
    w_occ       = 2'(r_s0_v) + 2'(r_s1_v) + 2'(r_inflight);
    w_pop       = r_s0_v & m_if.m_ready;
    w_ren       = rrst_n && (w_avail != '0) && ((w_occ - 2'(w_pop)) < 2'd2);
    w_rbin_next = r_rbin + (ADDRSIZE+1)'(w_ren);
  end

  // Buffer update: a pop shifts slot1 forward, then returning data fills
  // the oldest free position so FIFO order always holds.
  always_comb begin
    w_s0_v_n = r_s0_v;
    w_s0_d_n = r_s0_d;
    w_s1_v_n = r_s1_v;
    w_s1_d_n = r_s1_d;
    if (w_pop) begin
      w_s0_v_n = r_s1_v;
      if (r_s1_v) begin
        w_s0_d_n = r_s1_d;
      end
      w_s1_v_n = 1'b0;
    end
    if (r_inflight) begin
      if (!w_s0_v_n) begin
        w_s0_v_n = 1'b1;
        w_s0_d_n = rdata_mem;
      end else begin
        w_s1_v_n = 1'b1;
        w_s1_d_n = rdata_mem;
      end
    end
  end

  // Occupancy seen by the read side after this edge: unread memory words
  // plus buffered words plus the read being issued now.
  always_comb begin
    w_avail_next  = w_wbin - w_rbin_next;
    w_occ_next    = 2'(w_s0_v_n) + 2'(w_s1_v_n) + 2'(w_ren);
    w_rlevel_next = w_avail_next + (ADDRSIZE+1)'(w_occ_next);
  end

  // State and registered status outputs.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rbin     <= '0;
      rptr       <= '0;
      r_s0_v     <= 1'b0;
      r_s0_d     <= '0;
      r_s1_v     <= 1'b0;
      r_s1_d     <= '0;
      r_inflight <= 1'b0;
      rlevel     <= '0;
      aempty     <= 1'b1;
      rempty     <= 1'b1;
    end else begin
      r_rbin     <= w_rbin_next;
      rptr       <= w_rbin_next ^ (w_rbin_next >> 1);
      r_s0_v     <= w_s0_v_n;
      r_s0_d     <= w_s0_d_n;
      r_s1_v     <= w_s1_v_n;
      r_s1_d     <= w_s1_d_n;
      r_inflight <= w_ren;
      rlevel     <= w_rlevel_next;
      aempty     <= (w_rlevel_next <= (ADDRSIZE+1)'(AEMPTY_THRESH));
      rempty     <= (w_rlevel_next == '0);
    end
  end

  assign ren          = w_ren;
  assign raddr        = r_rbin[ADDRSIZE-1:0];
  assign m_if.m_valid = r_s0_v;
  assign m_if.m_data  = r_s0_d;

endmodule

// File: tb/tb_rfifo_stream_rd.sv
// Bench for rfifo_stream_rd: a write-side model fills a memory array and a
// Gray write pointer; the scoreboard expects words in write order and
// rlevel = words written - words consumed.
module tb_rfifo_stream_rd;
  localparam int AW = 4;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic [AW:0]   rq2_wptr = '0;
  logic [AW:0]   rptr;
  logic [AW-1:0] raddr;
  logic          ren;
  logic [DW-1:0] rdata_mem;
  logic [AW:0]   rlevel;
  logic          aempty;
  logic          rempty;

  rfifo_stream_rd_if #(.DATASIZE(DW)) s_if ();

  rfifo_stream_rd #(.ADDRSIZE(AW), .DATASIZE(DW), .AEMPTY_THRESH(2)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rq2_wptr  (rq2_wptr),
    .rptr      (rptr),
    .raddr     (raddr),
    .ren       (ren),
    .rdata_mem (rdata_mem),
    .m_if      (s_if),
    .rlevel    (rlevel),
    .aempty    (aempty),
    .rempty    (rempty)
  );

  always #5 rclk = ~rclk;

  // Memory with one cycle of registered read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge rclk) if (ren) rdata_mem <= mem[raddr];

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] ren_log[$];
  logic [AW:0]   rptr_log[$];
  int            wcount, pop_cnt, rd_cnt;
  logic [AW:0]   exp_level;
  bit            lvl_ok, prev_stall;
  logic [DW-1:0] prev_data;
  int            n_tests = 0;
  int            n_fail = 0;

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    ren_log.delete();
    rptr_log.delete();
    wcount  = 0;
    pop_cnt = 0;
    rd_cnt  = 0;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    logic [AW:0] wc;
    mem[wcount[AW-1:0]] = d;
    wcount++;
    wc = wcount[AW:0];
    rq2_wptr = gray(wc);
    exp_q.push_back(d);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rptr"},    32'(rptr),        32'd0);
    chk({tag, "_raddr"},   32'(raddr),       32'd0);
    chk({tag, "_ren"},     32'(ren),         32'd0);
    chk({tag, "_mvalid"},  32'(s_if.m_valid), 32'd0);
    chk({tag, "_mdata"},   32'(s_if.m_data), 32'd0);
    chk({tag, "_rlevel"},  32'(rlevel),      32'd0);
    chk({tag, "_aempty"},  32'(aempty),      32'd1);
    chk({tag, "_rempty"},  32'(rempty),      32'd1);
  endtask

  // Holds reset for two edges with random inputs, then releases.
  task automatic do_reset(input bit check);
    rrst_n = 1'b0;
    clear_model();
    repeat (2) begin
      rq2_wptr    = AW'($urandom);
      s_if.m_ready = 1'($urandom);
      step();
    end
    if (check) chk_reset_outputs("reset");
    rq2_wptr     = '0;
    s_if.m_ready = 1'b0;
    step();
    rrst_n = 1'b1;
  endtask

  // Writes n random words whenever the FIFO has room, with random
  // backpressure, until every written word has been consumed.
  task automatic run_stream(input int n, input int rdy_pct);
    int written = 0;
    int budget  = 0;
    while ((written < n || exp_q.size() != 0) && budget < 4000) begin
      step();
      s_if.m_ready = ($urandom_range(0, 99) < rdy_pct);
      if (written < n && $urandom_range(0, 3) != 0) begin
        int nw = $urandom_range(1, 3);
        for (int k = 0; k < nw; k++) begin
          if (written < n && (wcount - pop_cnt) < (1 << AW)) begin
            write_word(DW'($urandom_range(0, 255)));
            written++;
          end
        end
      end
      budget++;
    end
    chk("stream_done", 32'(budget < 4000), 32'd1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge rclk) begin
    int lv;
    if (!rrst_n) begin
      lvl_ok     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (lvl_ok) begin
        chk("rlevel", 32'(rlevel), 32'(exp_level));
        chk("aempty", 32'(aempty), 32'(exp_level <= 2));
        chk("rempty", 32'(rempty), 32'(exp_level == 0));
      end
      if (prev_stall) begin
        chk("hold_valid", 32'(s_if.m_valid), 32'd1);
        chk("hold_data",  32'(s_if.m_data),  32'(prev_data));
      end
      chk("rptr", 32'(rptr), 32'(gray(rd_cnt[AW:0])));
      rptr_log.push_back(rptr);
      if (ren) begin
        chk("raddr", 32'(raddr), 32'(rd_cnt[AW-1:0]));
        chk("ren_avail", 32'(wcount != rd_cnt), 32'd1);
        ren_log.push_back(raddr);
        rd_cnt++;
        chk("credit", 32'((rd_cnt - pop_cnt) <= 3), 32'd1);
      end
      if (s_if.m_valid && s_if.m_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_nonempty", 32'd0, 32'd1);
        end else begin
          chk("data", 32'(s_if.m_data), 32'(exp_q.pop_front()));
        end
        pop_cnt++;
      end
      prev_stall = s_if.m_valid && !s_if.m_ready;
      prev_data  = s_if.m_data;
      lv         = wcount - pop_cnt;
      exp_level  = lv[AW:0];
      lvl_ok     = 1'b1;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random tests ----------------
  initial begin
    int st;
    s_if.m_ready = 1'b0;

    // Reset values, then a single word.
    do_reset(1'b1);
    step();
    write_word(8'hA5);
    @(negedge rclk);
    chk("single_ren", 32'(ren), 32'd1);
    chk("single_raddr", 32'(raddr), 32'd0);
    step();
    @(negedge rclk);
    chk("single_rptr", 32'(rptr), 32'b00001);
    step();
    s_if.m_ready = 1'b1;
    @(negedge rclk);
    chk("single_mvalid", 32'(s_if.m_valid), 32'd1);
    chk("single_mdata", 32'(s_if.m_data), 32'hA5);
    step();
    @(negedge rclk);
    chk("single_empty_valid", 32'(s_if.m_valid), 32'd0);
    chk("single_rempty", 32'(rempty), 32'd1);

    // Backpressure: five words, consumer stalled.
    do_reset(1'b0);
    step();
    for (int i = 0; i < 5; i++) write_word(DW'(8'h10 + i));
    chk("bp_wptr", 32'(rq2_wptr), 32'b00111);
    repeat (6) step();
    @(negedge rclk);
    chk("bp_ren_count", 32'(ren_log.size()), 32'd2);
    chk("bp_ren0", 32'(ren_log[0]), 32'd0);
    chk("bp_ren1", 32'(ren_log[1]), 32'd1);
    chk("bp_mdata", 32'(s_if.m_data), 32'h10);
    chk("bp_rlevel", 32'(rlevel), 32'd5);
    step();
    s_if.m_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge rclk);
      chk("bp_stream_valid", 32'(s_if.m_valid), 32'd1);
      chk("bp_stream_data", 32'(s_if.m_data), 32'(8'h10 + k));
      step();
    end
    @(negedge rclk);
    chk("bp_drained", 32'(s_if.m_valid), 32'd0);

    // Wrap-around of the read pointer.
    do_reset(1'b0);
    run_stream(30, 80);
    run_stream(4, 100);
    @(negedge rclk);
    chk("wrap_reads", 32'(ren_log.size()), 32'd34);
    chk("wrap_raddr30", 32'(ren_log[30]), 32'd14);
    chk("wrap_raddr31", 32'(ren_log[31]), 32'd15);
    chk("wrap_raddr32", 32'(ren_log[32]), 32'd0);
    chk("wrap_raddr33", 32'(ren_log[33]), 32'd1);
    st = 0;
    foreach (rptr_log[i]) begin
      if (st == 0 && rptr_log[i] == 5'b11000) st = 1;
      else if (st == 1 && rptr_log[i] == 5'b10001) st = 2;
      else if (st == 2 && rptr_log[i] == 5'b00000) st = 3;
    end
    chk("wrap_rptr_seq", 32'(st), 32'd3);
    chk("wrap_rempty", 32'(rempty), 32'd1);

    // Almost-empty threshold crossing.
    do_reset(1'b0);
    step();
    for (int i = 0; i < 3; i++) write_word(DW'(8'h30 + i));
    repeat (4) step();
    @(negedge rclk);
    chk("ae_rlevel3", 32'(rlevel), 32'd3);
    chk("ae_aempty0", 32'(aempty), 32'd0);
    step();
    s_if.m_ready = 1'b1;
    step();
    s_if.m_ready = 1'b0;
    @(negedge rclk);
    chk("ae_rlevel2", 32'(rlevel), 32'd2);
    chk("ae_aempty1", 32'(aempty), 32'd1);
    run_stream(0, 100);

    // Asynchronous reset with a presented word and a read in flight.
    do_reset(1'b0);
    step();
    for (int i = 0; i < 3; i++) write_word(DW'(8'h50 + i));
    step();
    step();
    chk("ar_pre_valid", 32'(s_if.m_valid), 32'd1);
    #2;
    rrst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    clear_model();
    rq2_wptr = '0;
    repeat (2) step();
    rrst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge rclk);
      chk("ar_no_stale", 32'(s_if.m_valid), 32'd0);
      step();
    end
    run_stream(20, 60);

    // Random traffic with mixed backpressure.
    run_stream(200, 50);
    run_stream(100, 95);
    @(negedge rclk);
    chk("final_rempty", 32'(rempty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
